// File: rtl/seq_serializer.sv
// ---------------------------------------------------------------------------
// seq_serializer
//
// Parallel-to-serial stimulus stage feeding the sequence detector's serial
// input. WIDTH-bit words arrive over a valid/ready handshake, are buffered in
// a holding register, then moved into a shift register and sent MSB first,
// one bit per clock. Back-to-back words stream with no gap bit.
//
// Optional feature (macro SEQ_SERIALIZER_LOOP_EN):
//   defined   - the shift register rotates; with no new word buffered, the
//               current word is re-sent indefinitely (IDLE only via reset).
//   undefined - after the last bit with hold empty, the FSM returns to IDLE.
//
// Handshake: a word transfers on a rising clk edge where din_valid and
// din_ready are both 1. din_ready is ~hold_full straight from a flop, so it
// never depends combinationally on din_valid. While din_ready is 0, din is
// ignored.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   din        in   [WIDTH]  parallel word to serialise
//   din_valid  in   din holds a word to transfer
//   din_ready  out  holding register empty, a word can be accepted
//   x          out  serial bit to the detector (IDLE_BIT when idle)
//   x_valid    out  x carries a word bit this cycle
//   busy       out  a word is in flight or buffered
//   bit_idx    out  [CNTW] index of current bit within its word, 0 = MSB
//   state_dbg  out  current FSM state (0 = IDLE, 1 = SHIFT)
// ---------------------------------------------------------------------------
module seq_serializer #(
    parameter int   WIDTH    = 24,
    parameter int   CNTW     = 5,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic [CNTW-1:0]  bit_idx,
    output logic             state_dbg
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic             x_n, x_valid_n;
    logic [CNTW-1:0]  bit_idx_n;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] shreg_adv;

    assign accept   = din_valid & ~hold_full;
    assign last_bit = (bit_idx == CNTW'(WIDTH - 1));

    // x always mirrors shreg[WIDTH-1] while shifting, so the next bit on x
    // is shreg[WIDTH-2] of the pre-edge register.
`ifdef SEQ_SERIALIZER_LOOP_EN
    // Rotate: after WIDTH steps the register holds the original word again,
    // which is what lets a word re-send without reloading.
    assign shreg_adv = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
`else
    assign shreg_adv = shreg << 1;
`endif

    assign din_ready = ~hold_full;
    assign busy      = (state == S_SHIFT) | hold_full;
    assign state_dbg = state;

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        hold_n      = hold;
        hold_full_n = hold_full;
        x_n         = x;
        x_valid_n   = x_valid;
        bit_idx_n   = bit_idx;

        // Accept and load-from-hold are mutually exclusive: accept needs
        // hold empty, loading needs hold full.
        if (accept) begin
            hold_n      = din;
            hold_full_n = 1'b1;
        end

        case (state)
            S_IDLE: begin
                x_n       = IDLE_BIT;
                x_valid_n = 1'b0;
                bit_idx_n = '0;
                if (hold_full) begin
                    state_n     = S_SHIFT;
                    shreg_n     = hold;
                    hold_full_n = 1'b0;
                    x_n         = hold[WIDTH-1];
                    x_valid_n   = 1'b1;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    if (hold_full) begin
                        // Buffered word follows with no gap bit.
                        shreg_n     = hold;
                        hold_full_n = 1'b0;
                        x_n         = hold[WIDTH-1];
                        x_valid_n   = 1'b1;
                        bit_idx_n   = '0;
                    end else begin
`ifdef SEQ_SERIALIZER_LOOP_EN
                        shreg_n   = shreg_adv;
                        x_n       = shreg[WIDTH-2];
                        x_valid_n = 1'b1;
                        bit_idx_n = '0;
`else
                        state_n   = S_IDLE;
                        shreg_n   = '0;
                        x_n       = IDLE_BIT;
                        x_valid_n = 1'b0;
                        bit_idx_n = '0;
`endif
                    end
                end else begin
                    shreg_n   = shreg_adv;
                    x_n       = shreg[WIDTH-2];
                    x_valid_n = 1'b1;
                    bit_idx_n = bit_idx + CNTW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            x         <= IDLE_BIT;
            x_valid   <= 1'b0;
            bit_idx   <= '0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            x         <= x_n;
            x_valid   <= x_valid_n;
            bit_idx   <= bit_idx_n;
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// ---------------------------------------------------------------------------
// tb_seq_serializer
//
// Directed bench for seq_serializer (WIDTH=24). Inputs change 1 time unit
// after a rising edge; outputs are checked at the same point, i.e. they show
// the state loaded by the edge just passed.
// ---------------------------------------------------------------------------
module tb_seq_serializer;

    localparam int WIDTH = 24;
    localparam int CNTW  = 5;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic [CNTW-1:0]  bit_idx;
    logic             state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [0:0] exp_q[$];

    seq_serializer #(
        .WIDTH    (WIDTH),
        .CNTW     (CNTW),
        .IDLE_BIT (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .x_valid   (x_valid),
        .busy      (busy),
        .bit_idx   (bit_idx),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".x"},         32'(x),         32'd0);
        check({tag, ".x_valid"},   32'(x_valid),   32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".din_ready"}, 32'(din_ready), 32'd1);
        check({tag, ".bit_idx"},   32'(bit_idx),   32'd0);
        check({tag, ".state"},     32'(state_dbg), 32'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    logic [WIDTH-1:0] w_single;
    logic [WIDTH-1:0] w1, w2, w3;
    logic             exp_ready;

    initial begin
        w_single = 24'h0C9094;
        w1       = 24'hFFFFFF;
        w2       = 24'h000000;
        w3       = 24'hA5C33C;

        // Reset and idle output.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check_idle("idle");
        end

        // Reset mid-word, with a second word sitting in hold.
        din       = w_single;
        din_valid = 1'b1;
        tick();                               // accept word A
        din_valid = 1'b0;
        tick();                               // A loads, bit_idx 0
        check("mid.first_x", 32'(x), 32'(w_single[WIDTH-1]));
        din       = 24'h123456;
        din_valid = 1'b1;
        tick();                               // accept word B into hold
        din_valid = 1'b0;
        check("mid.busy",      32'(busy),      32'd1);
        check("mid.din_ready", 32'(din_ready), 32'd0);
        for (int i = 0; i < 9; i++) tick();
        check("mid.bit_idx", 32'(bit_idx), 32'd10);
        check("mid.x",       32'(x),       32'(w_single[WIDTH-1-10]));
        rst = 1'b0;
        #1;
        check_idle("mid.async_rst");
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("mid.after.x_valid", 32'(x_valid), 32'd0);
            check("mid.after.x",       32'(x),       32'd0);
        end

        // Back-to-back stream with backpressure on the third word.
        // Edge k: k=0 accepts w1, k=1 loads w1, k=2 accepts w2, k=25 loads
        // w2, k=26 accepts w3, k=49 loads w3; bits run after edges 1..72.
        exp_q.delete();
        for (int b = WIDTH - 1; b >= 0; b--) exp_q.push_back(w1[b]);
        for (int b = WIDTH - 1; b >= 0; b--) exp_q.push_back(w2[b]);
        for (int b = WIDTH - 1; b >= 0; b--) exp_q.push_back(w3[b]);
        din       = w1;
        din_valid = 1'b1;
        for (int k = 0; k < 80; k++) begin
            tick();
            exp_ready = (k == 1) || (k == 25) || (k >= 49);
            check("bb.din_ready", 32'(din_ready), 32'(exp_ready));
            if (k == 0) begin
                check("bb.x_valid0", 32'(x_valid), 32'd0);
                check("bb.busy0",    32'(busy),    32'd1);
            end else if (k <= 72) begin
                check("bb.x_valid", 32'(x_valid), 32'd1);
                check("bb.x",       32'(x),       32'(exp_q.pop_front()));
                check("bb.bit_idx", 32'(bit_idx), 32'((k - 1) % WIDTH));
                check("bb.busy",    32'(busy),    32'd1);
            end else begin
`ifdef SEQ_SERIALIZER_LOOP_EN
                check("bb.loop.x_valid", 32'(x_valid), 32'd1);
                check("bb.loop.x",       32'(x),       32'(w3[WIDTH-1-((k - 49) % WIDTH)]));
                check("bb.loop.bit_idx", 32'(bit_idx), 32'((k - 1) % WIDTH));
                check("bb.loop.busy",    32'(busy),    32'd1);
`else
                check("bb.tail.x_valid", 32'(x_valid), 32'd0);
                check("bb.tail.x",       32'(x),       32'd0);
                check("bb.tail.busy",    32'(busy),    32'd0);
`endif
            end
            // Drive for the next edge; while din_ready=0, din carries junk
            // that must never be taken.
            if (k == 1)       din = w2;
            else if (k == 25) din = w3;
            else if (k >= 49) din_valid = 1'b0;
            else              din = WIDTH'($urandom);
        end

        // Single word from a clean reset.
        do_reset();
        din       = w_single;
        din_valid = 1'b1;
        tick();                               // edge N: accept
        din_valid = 1'b0;
        din       = '0;
        check("one.din_ready", 32'(din_ready), 32'd0);
        check("one.x_valid",   32'(x_valid),   32'd0);
        check("one.busy",      32'(busy),      32'd1);
        for (int i = 0; i < WIDTH; i++) begin
            tick();                           // edge N+1+i
            check("one.x",       32'(x),       32'(w_single[WIDTH-1-i]));
            check("one.x_valid", 32'(x_valid), 32'd1);
            check("one.bit_idx", 32'(bit_idx), 32'(i));
        end
`ifdef SEQ_SERIALIZER_LOOP_EN
        for (int j = 0; j < 100; j++) begin
            tick();
            check("loop.x",       32'(x),       32'(w_single[WIDTH-1-(j % WIDTH)]));
            check("loop.x_valid", 32'(x_valid), 32'd1);
            check("loop.bit_idx", 32'(bit_idx), 32'(j % WIDTH));
        end
`else
        for (int j = 0; j < 5; j++) begin
            tick();
            check_idle("one.after");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-to-serial stimulus stage sitting directly upstream of the sequence detector; drives the detector's serial input `x`, one bit per clock.
- Accepts WIDTH-bit words over a valid/ready handshake and double-buffers them (shift register plus one holding register).
- Back-to-back words stream with no gap bit.
- Serialisation is MSB first.

Parameters:
- WIDTH, 24: bits per word. Legal range is 2..32.
- CNTW, 5: width of bit_idx. Must satisfy 2**CNTW >= WIDTH.
- IDLE_BIT, 1'b0: level driven on `x` when no word is being sent.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  WIDTH  parallel word to serialise.
- din_valid  in  1  `din` holds a word to transfer.
- din_ready  out  1  holding register is empty; a word can be accepted.
- x  out  1  serial bit to the detector.
- x_valid  out  1  `x` carries a word bit this cycle.
- busy  out  1  a word is in flight or buffered.
- bit_idx  out  CNTW  index of the current bit within its word; 0 is the MSB.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; shift register and holding register are cleared; hold_full=0.
  - Outputs: x=IDLE_BIT, x_valid=0, din_ready=1, busy=0, bit_idx=0.
- Registered outputs:
  - x, x_valid and bit_idx are flop outputs.
  - din_ready = ~hold_full, decoded from a flop only; there is no combinational path from din_valid.
- Accept:
  - A transfer happens on a rising edge where din_valid && din_ready.
  - din is written to the holding register and hold_full goes to 1.
  - While din_ready=0, din is ignored.
- FSM states: IDLE and SHIFT.
- IDLE:
  - x=IDLE_BIT, x_valid=0.
  - If hold_full at an edge: the holding register moves into the shift register, hold_full goes to 0, the state goes to SHIFT, and x takes word[WIDTH-1] with bit_idx=0.
  - Latency: word accepted at edge N, first bit on x after edge N+1.
- SHIFT:
  - Each edge, x takes the next lower bit and bit_idx increments.
  - The last bit is bit_idx=WIDTH-1. At the edge ending the last bit:
    - if hold_full, the buffered word loads immediately. x takes its MSB, bit_idx=0, and there is no gap cycle.
    - else, the state goes to IDLE. x=IDLE_BIT and x_valid=0 from the next cycle (LOOP_EN off).
- Simultaneous events:
  - Load-from-hold and accept at the same edge cannot occur, because din_ready is the pre-edge ~hold_full.
  - A word accepted at edge N while SHIFT is at bit_idx<WIDTH-1 waits in hold. It always reaches the shift register before the current word ends, because WIDTH >= 2.
- busy = (state==SHIFT) | hold_full.
- Reset mid-word: the word in flight and any buffered word are discarded, with no partial completion. x returns to IDLE_BIT asynchronously.
- din_valid held high with constant din: consecutive words are accepted each time hold empties. The result is a continuous repeating stream.

Optional Feature:
- Macro: SEQ_SERIALIZER_LOOP_EN.
- Defined:
  - The shift register rotates (MSB recirculates into the LSB) instead of shifting in zeros.
  - At the end of a word with hold empty, the FSM stays in SHIFT and re-sends the same word indefinitely: bit_idx wraps WIDTH-1 -> 0 and x_valid stays 1.
  - A newly buffered word replaces it at the next word boundary.
  - IDLE is reached only from reset.
- Undefined: behaviour is exactly as above, and the rotate logic is absent.

Test Plan:
- Reset, idle output: hold rst=0 for 2 cycles, then release with din_valid=0 for 10 cycles -> x=0, x_valid=0, busy=0 and din_ready=1 throughout.
- Single word: accept din=24'h0C9094 at edge N -> from edge N+1, x over 24 cycles = 0000_1100_1001_0000_1001_0100 with bit_idx 0..23. Then IDLE with x=0, x_valid=0.
- Back-to-back: din_valid held high, words 24'hFFFFFF then 24'h000000 -> 48 consecutive x_valid=1 cycles, 24 ones then 24 zeros, no gap.
- Backpressure: present a third word while hold_full=1 -> din_ready=0 and din is ignored until the second word starts. The third word then follows with no gap.
- Reset mid-word: assert rst at bit_idx=10 -> x=0, x_valid=0 and busy=0 immediately. After release, no bits of the old word appear.
- Loop (SEQ_SERIALIZER_LOOP_EN defined): one word 24'h0C9094, then din_valid=0 -> the pattern repeats every 24 cycles for 100 cycles and x_valid stays 1.
